seg_display_driver: RTL and testbench
=====================================

# seg_display_driver

Multiplexed 4-digit seven-segment display driver for the board's output side: it presents a 16-bit processor value as four hexadecimal digits on common-anode displays. It is the output-path counterpart of the push-button input conditioning. A frame-synchronous shadow register prevents torn digits when the value changes mid-scan. It sits between the processor's output register and the board's anode/segment pins.

## Interface
- REFRESH_DIV, 100_000: clk cycles each digit stays lit; 1 ms at 100 MHz. Legal range 2 to 2^20−1.
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  reset; synchronous, active-low.
- value  input  16  value to display; nibble k drives digit k, with digit 0 rightmost.
- load  input  1  single-cycle strobe; value is captured into the shadow register.
- dp  input  4  decimal-point request per digit, active-high; sampled live, not shadowed.
- blank  input  1  high forces all anodes off; scanning continues.
- pending  output  1  high from capture until the shadow is committed to the display.
- an  output  4  anode enables, active-low, one-hot-low when not blanked.
- seg  output  7  segments a..g as seg[0]..seg[6], active-low.
- dp_n  output  1  decimal point, active-low.

## Operation
- Refresh counter div_cnt (20 bit) counts 0..REFRESH_DIV−1 and wraps to 0. The terminal count produces `tick` for one cycle.
- Digit index dig (2 bit) increments on tick and wraps from 3 to 0. `frame` = tick & (dig==3).
- Shadow register shd[15:0]: on load, shd ← value and pending ← 1.
- Active register act[15:0]: on frame with pending=1, act ← shd and pending ← 0.
- Load and frame in the same cycle:
  - act takes the old shd.
  - shd takes the new value.
  - pending stays 1, so the new value commits at the next frame.
- load while pending=1 overwrites shd. Only the latest value is ever shown.
- Decode is hex:
  - 0–9 and A, b, C, d, E, F in standard forms.
  - 0 = 7'b1000000. 8 = 7'b0000000. F = 7'b0001110.
- Outputs are registered each cycle from dig, act, dp and blank:
  - an ← blank ? 4'b1111 : ~(4'b0001 << dig)
  - seg ← decode(act[4·dig+3 : 4·dig])
  - dp_n ← ~dp[dig]
- blank affects an only. seg and dp_n keep updating.

## Timing
- Reset values: an=4'b1111, seg=7'b1111111, dp_n=1, pending=0, div_cnt=0, dig=0, shd=0, act=0.
- First cycle after rst_n rises: the registered outputs update at that edge. an=4'b1110 and seg=7'b1000000 (digit 0 showing "0").
- Output latency is 1 cycle from dig, act, dp or blank to the pins.
- The pending rise is visible on the edge after load.
- Load-to-display latency ranges from 1 cycle (load at the frame-minus-one cycle) to 4·REFRESH_DIV cycles.
- dig changes on the edge where div_cnt wraps. The pins follow one cycle later, so each digit is lit exactly REFRESH_DIV cycles.
- rst_n low mid-scan: all state returns to reset values at the next edge. A pending load is discarded.
- Full frame period is 4·REFRESH_DIV cycles.

## Configuration
- SEVSEG_LZ_BLANK_EN defined: leading-zero blanking.
  - Digit k (k≥1) has its segments forced to 7'b1111111 when act nibbles k..3 are all zero.
  - Digit 0 is always shown.
  - The anode still scans and dp_n is unaffected.
  - The blank mask is computed from act, so it changes only at frame commits.
- SEVSEG_LZ_BLANK_EN undefined: all four digits are always decoded. An act of 0x0042 displays "0042".

## Structure
- Package seg_pkg holds:
  - the 7-bit segment encodings for 0–F;
  - SEG_OFF = 7'b1111111;
  - NUM_DIGITS = 4;
  - the default REFRESH_DIV.
- Sub-module hex_to_seg: combinational 4-bit nibble to active-low 7-bit segments, built on seg_pkg.
- The top contains the counter, digit index, shadow/active registers, the optional blank mask and the output registers.

## Test plan
All scenarios use REFRESH_DIV=4.
- Reset: hold rst_n=0 for 3 cycles → an=1111, seg=1111111, dp_n=1, pending=0. On the first edge after release → an=1110, seg=1000000.
- Scan: no load, run 16 cycles → an walks 1110, 1101, 1011, 0111, each for exactly 4 cycles, then repeats.
- Commit: load with value=16'h1A3F at mid-frame → pending=1 until the frame edge. Next frame shows digit0=F (0001110), digit1=3 (0110000), digit2=A (0001000), digit3=1 (1111001).
- Simultaneous events:
  - load 16'h1111, then load 16'h2222 exactly on the frame cycle.
  - Next frame shows 1111 with pending=1.
  - The following frame shows 2222 with pending=0.
- blank=1 for one frame → an=1111 throughout; dig keeps advancing. After release, the scan resumes in phase. dp=4'b0100 → dp_n=0 only while an=1011.
- SEVSEG_LZ_BLANK_EN with value=16'h0042 → digits 3 and 2 seg=1111111, digit1=4, digit0=2. Value 16'h0000 → only digit0 shows "0".

Source files
------------

// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment display driver.
// Holds widths, the default refresh divider, the blank pattern and the
// active-low hex segment table (seg[0]=a .. seg[6]=g).
package seg_pkg;

  localparam int unsigned NUM_DIGITS          = 4;
  localparam int unsigned NIB_W               = 4;
  localparam int unsigned SEG_W               = 7;
  localparam int unsigned VAL_W               = 16;
  localparam int unsigned DIV_W               = 20;
  localparam int unsigned REFRESH_DIV_DEFAULT = 100_000;

  localparam logic [SEG_W-1:0] SEG_OFF = 7'b1111111;

  // Index n holds the glyph for hex digit n (element 15 listed first).
  localparam logic [15:0][SEG_W-1:0] SEG_LUT = {
    7'b0001110,  // F
    7'b0000110,  // E
    7'b0100001,  // d
    7'b1000110,  // C
    7'b0000011,  // b
    7'b0001000,  // A
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

endpackage

// File: rtl/seg_display_driver_hex_to_seg.sv
// hex_to_seg: combinational nibble to active-low seven-segment decode.
// Ports: nib  - 4-bit hex digit
//        seg_c - segments a..g on seg_c[0]..seg_c[6], active-low
module hex_to_seg
  import seg_pkg::*;
(
  input  logic [NIB_W-1:0] nib,
  output logic [SEG_W-1:0] seg_c
);

  assign seg_c = SEG_LUT[nib];

endmodule

// File: rtl/seg_display_driver.sv
// seg_display_driver: multiplexed 4-digit common-anode hex display driver.
// A shadow register captures value on load; it is committed to the active
// (displayed) register only at the end of a full scan so digits never tear.
// Optional build macro: SEVSEG_LZ_BLANK_EN enables leading-zero blanking.
// Ports:
//   clk, rst_n    - clock, synchronous active-low reset
//   value, load   - 16-bit value and single-cycle capture strobe
//   dp, blank     - live decimal-point requests, force-all-anodes-off
//   pending       - shadow holds a value not yet on the display
//   an, seg, dp_n - active-low anode, segment and decimal-point pins
module seg_display_driver
  import seg_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = REFRESH_DIV_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [VAL_W-1:0]      value,
  input  logic                  load,
  input  logic [NUM_DIGITS-1:0] dp,
  input  logic                  blank,
  output logic                  pending,
  output logic [NUM_DIGITS-1:0] an,
  output logic [SEG_W-1:0]      seg,
  output logic                  dp_n
);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);

  logic [DIV_W-1:0]      div_cnt;
  logic [1:0]            dig;
  logic [VAL_W-1:0]      shd;
  logic [VAL_W-1:0]      act;
  logic                  tick_c;
  logic                  frame_c;
  logic [NIB_W-1:0]      nib_c;
  logic [SEG_W-1:0]      dec_c;
  logic [SEG_W-1:0]      seg_nxt_c;
  logic [NUM_DIGITS-1:0] lz_mask_c;

  assign tick_c  = (div_cnt == DIV_LAST);
  assign frame_c = tick_c && (dig == 2'd3);
  assign nib_c   = act[{dig, 2'b00} +: NIB_W];

  hex_to_seg u_dec (
    .nib   (nib_c),
    .seg_c (dec_c)
  );

`ifdef SEVSEG_LZ_BLANK_EN
  // Digit k is a leading zero when every nibble from k upward is zero.
  always_comb begin
    lz_mask_c    = '0;
    lz_mask_c[1] = (act[15:4]  == 12'h000);
    lz_mask_c[2] = (act[15:8]  == 8'h00);
    lz_mask_c[3] = (act[15:12] == 4'h0);
  end
`else
  assign lz_mask_c = '0;
`endif

  assign seg_nxt_c = lz_mask_c[dig] ? SEG_OFF : dec_c;

  // Refresh divider and digit index.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt <= '0;
      dig     <= '0;
    end else begin
      div_cnt <= tick_c ? '0 : div_cnt + DIV_W'(1);
      if (tick_c) dig <= dig + 2'd1;
    end
  end

  // Shadow/active pair; a load coinciding with a frame keeps pending set
  // so the newer value is committed on the following frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shd     <= '0;
      act     <= '0;
      pending <= 1'b0;
    end else begin
      if (load) shd <= value;
      if (frame_c && pending) act <= shd;
      if (load) pending <= 1'b1;
      else if (frame_c) pending <= 1'b0;
    end
  end

  // Pin registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      an   <= 4'b1111;
      seg  <= SEG_OFF;
      dp_n <= 1'b1;
    end else begin
      an   <= blank ? 4'b1111 : ~(4'b0001 << dig);
      seg  <= seg_nxt_c;
      dp_n <= ~dp[dig];
    end
  end

endmodule

// File: tb/tb_seg_display_driver.sv
// Directed bench for seg_display_driver with REFRESH_DIV=4 (16-cycle frame).
module tb_seg_display_driver;

  localparam logic [6:0] G0   = 7'b1000000;
  localparam logic [6:0] G1   = 7'b1111001;
  localparam logic [6:0] G2   = 7'b0100100;
  localparam logic [6:0] G3   = 7'b0110000;
  localparam logic [6:0] G4   = 7'b0011001;
  localparam logic [6:0] GA   = 7'b0001000;
  localparam logic [6:0] GF   = 7'b0001110;
  localparam logic [6:0] GOFF = 7'b1111111;
`ifdef SEVSEG_LZ_BLANK_EN
  localparam logic [6:0] GLZ  = 7'b1111111;
`else
  localparam logic [6:0] GLZ  = 7'b1000000;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] value;
  logic        load;
  logic [3:0]  dp;
  logic        blank;
  logic        pending;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp_n;

  int   checks   = 0;
  int   failures = 0;
  logic pend_m;

  always #5 clk = ~clk;

  seg_display_driver #(.REFRESH_DIV(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .value   (value),
    .load    (load),
    .dp      (dp),
    .blank   (blank),
    .pending (pending),
    .an      (an),
    .seg     (seg),
    .dp_n    (dp_n)
  );

  task automatic chk(input string tag, input int idx, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s[%0d] observed=%h expected=%h", tag, idx, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One 16-cycle scan starting at digit 0, with up to two loads at given steps.
  task automatic frame(input int fid,
                       input logic [6:0] s0, input logic [6:0] s1,
                       input logic [6:0] s2, input logic [6:0] s3,
                       input int ld_a, input logic [15:0] val_a,
                       input int ld_b, input logic [15:0] val_b,
                       input logic blk, input logic [3:0] dpv);
    logic [6:0] s [4];
    logic [3:0] e_an;
    int d;
    s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
    blank = blk;
    dp    = dpv;
    for (int i = 0; i < 16; i++) begin
      d = i / 4;
      load = (i == ld_a) || (i == ld_b);
      if (i == ld_a) value = val_a;
      if (i == ld_b) value = val_b;
      step();
      load = 1'b0;
      if ((i == ld_a) || (i == ld_b)) pend_m = 1'b1;
      else if (i == 15) pend_m = 1'b0;
      e_an = 4'b1111;
      if (!blk) e_an[d] = 1'b0;
      chk("an",      fid * 16 + i, {12'h000, an},  {12'h000, e_an});
      chk("seg",     fid * 16 + i, {9'h000, seg},  {9'h000, s[d]});
      chk("dp_n",    fid * 16 + i, {15'h0000, dp_n}, {15'h0000, ~dpv[d]});
      chk("pending", fid * 16 + i, {15'h0000, pending}, {15'h0000, pend_m});
    end
  endtask

  initial begin
    rst_n = 1'b0;
    value = 16'h0000;
    load  = 1'b0;
    dp    = 4'b0000;
    blank = 1'b0;
    pend_m = 1'b0;

    repeat (3) step();
    chk("rst_an",   0, {12'h000, an},  16'h000F);
    chk("rst_seg",  0, {9'h000, seg},  16'h007F);
    chk("rst_dp_n", 0, {15'h0000, dp_n}, 16'h0001);
    chk("rst_pend", 0, {15'h0000, pending}, 16'h0000);

    rst_n = 1'b1;
    // Scan of an all-zero active value, twice.
    frame(0, G0, G0, G0, G0, -1, 16'h0, -1, 16'h0, 1'b0, 4'b0000);
    frame(1, G0, G0, G0, G0, -1, 16'h0, -1, 16'h0, 1'b0, 4'b0000);
    // Mid-frame load, then commit at the frame edge.
    frame(2, G0, G0, G0, G0, 3, 16'h1A3F, -1, 16'h0, 1'b0, 4'b0000);
    frame(3, GF, G3, GA, G1, -1, 16'h0, -1, 16'h0, 1'b0, 4'b0000);
    // Load, then a second load on the frame cycle itself.
    frame(4, GF, G3, GA, G1, 5, 16'h1111, 15, 16'h2222, 1'b0, 4'b0000);
    frame(5, G1, G1, G1, G1, -1, 16'h0, -1, 16'h0, 1'b0, 4'b0000);
    frame(6, G2, G2, G2, G2, -1, 16'h0, -1, 16'h0, 1'b0, 4'b0000);
    // Blanked frame then resumed scan, decimal point on digit 2.
    frame(7, G2, G2, G2, G2, -1, 16'h0, -1, 16'h0, 1'b1, 4'b0100);
    frame(8, G2, G2, G2, G2, -1, 16'h0, -1, 16'h0, 1'b0, 4'b0100);
    // Leading-zero cases.
    frame(9,  G2, G2, G2, G2, 6, 16'h0042, -1, 16'h0, 1'b0, 4'b0000);
    frame(10, G2, G4, GLZ, GLZ, 8, 16'h0000, -1, 16'h0, 1'b0, 4'b0000);
    frame(11, G0, GLZ, GLZ, GLZ, -1, 16'h0, -1, 16'h0, 1'b0, 4'b0000);

    // Reset mid-scan with a load outstanding.
    value = 16'h5555;
    load  = 1'b1;
    step();
    load  = 1'b0;
    chk("mid_pend_set", 0, {15'h0000, pending}, 16'h0001);
    step();
    step();
    rst_n = 1'b0;
    step();
    chk("mid_rst_an",   0, {12'h000, an},  16'h000F);
    chk("mid_rst_seg",  0, {9'h000, seg},  16'h007F);
    chk("mid_rst_dp_n", 0, {15'h0000, dp_n}, 16'h0001);
    chk("mid_rst_pend", 0, {15'h0000, pending}, 16'h0000);
    rst_n  = 1'b1;
    pend_m = 1'b0;
    frame(12, G0, GLZ, GLZ, GLZ, -1, 16'h0, -1, 16'h0, 1'b0, 4'b0000);
    frame(13, G0, GLZ, GLZ, GLZ, -1, 16'h0, -1, 16'h0, 1'b0, 4'b0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
